// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: way codes, FSM states,
// default latencies and the packed result payload.
package mdu_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned WAY_W           = 3;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  localparam logic [WAY_W-1:0] WAY_MULT  = 3'b001;
  localparam logic [WAY_W-1:0] WAY_MULTU = 3'b010;
  localparam logic [WAY_W-1:0] WAY_DIV   = 3'b011;
  localparam logic [WAY_W-1:0] WAY_DIVU  = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // we=0 means the operation completes without touching HI/LO (divide by zero)
  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } mdu_result_t;

  function automatic logic way_valid(input logic [WAY_W-1:0] w);
    return (w == WAY_MULT) || (w == WAY_MULTU) || (w == WAY_DIV) || (w == WAY_DIVU);
  endfunction

  function automatic logic way_is_div(input logic [WAY_W-1:0] w);
    return (w == WAY_DIV) || (w == WAY_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit mult/div datapath, including divide-by-zero and
// signed-overflow handling.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [WAY_W-1:0]  way,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output mdu_result_t       res
);

  logic signed [2*DATA_W-1:0] s_prod;
  logic        [2*DATA_W-1:0] u_prod;
  logic signed [DATA_W-1:0]   s_quo;
  logic signed [DATA_W-1:0]   s_rem;
  logic        [DATA_W-1:0]   u_quo;
  logic        [DATA_W-1:0]   u_rem;
  logic        [DATA_W-1:0]   b_safe;
  logic                       div_zero;
  logic                       div_ovf;

  assign s_prod = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
  assign u_prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  // Dividing by 1 yields 0x80000000 rem 0 for the overflow case and keeps
  // the divider well defined for a zero divisor (result is discarded then).
  assign div_zero = (b == '0);
  assign div_ovf  = (a == {1'b1, {(DATA_W-1){1'b0}}}) && (b == '1);
  assign b_safe   = (div_zero || div_ovf) ? DATA_W'(1) : b;

  assign s_quo = $signed(a) / $signed(b_safe);
  assign s_rem = $signed(a) % $signed(b_safe);
  assign u_quo = a / b_safe;
  assign u_rem = a % b_safe;

  always_comb begin
    res = '0;
    case (way)
      WAY_MULT: begin
        res.we = 1'b1;
        res.hi = s_prod[2*DATA_W-1:DATA_W];
        res.lo = s_prod[DATA_W-1:0];
      end
      WAY_MULTU: begin
        res.we = 1'b1;
        res.hi = u_prod[2*DATA_W-1:DATA_W];
        res.lo = u_prod[DATA_W-1:0];
      end
      WAY_DIV: begin
        res.we = !div_zero;
        res.hi = s_rem;
        res.lo = s_quo;
      end
      WAY_DIVU: begin
        res.we = !div_zero;
        res.hi = u_rem;
        res.lo = u_quo;
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, models mult/div latency and
// raises busy / md_stall for the hazard unit.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WAY_W-1:0]  way,
  input  logic              HIw,
  input  logic              LOw,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              mh,
  input  logic              ml,
  input  logic              md_d,
  output logic [DATA_W-1:0] out,
  output logic              busy,
  output logic              md_stall
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mdu_result_t       pend_q, pend_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  mdu_result_t       arith_res;
  logic              accept;

  mdu_arith u_arith (
    .way (way),
    .a   (rs_data),
    .b   (rt_data),
    .res (arith_res)
  );

  assign accept = (state_q == IDLE) && start && way_valid(way);

  // State, counter, pending result and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state: accept in IDLE, count down in BUSY, commit on the last cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pend_d  = arith_res;
          cnt_d   = way_is_div(way) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d = BUSY;
        end else if (!start) begin
          if (HIw) begin
            hi_d = rs_data;
          end else if (LOw) begin
            lo_d = rs_data;
          end
        end
      end
      BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (pend_q.we) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == BUSY);
  assign md_stall = md_d && (start || busy);
  assign out      = mh ? hi_q : (ml ? lo_q : '0);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed HI/LO
// results, busy-length checks and reset/abort scenarios.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  way;
  logic        HIw;
  logic        LOw;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mh;
  logic        ml;
  logic        md_d;
  logic [31:0] out;
  logic        busy;
  logic        md_stall;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .way      (way),
    .HIw      (HIw),
    .LOw      (LOw),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .mh       (mh),
    .ml       (ml),
    .md_d     (md_d),
    .out      (out),
    .busy     (busy),
    .md_stall (md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    start = 1'b0; way = 3'b000; HIw = 1'b0; LOw = 1'b0;
    rs_data = '0; rt_data = '0; mh = 1'b0; ml = 1'b0; md_d = 1'b0;
  endtask

  task automatic chk_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    mh = 1'b1; ml = 1'b0; #1;
    check({tag, " mfhi"}, out, exp_hi);
    mh = 1'b0; ml = 1'b1; #1;
    check({tag, " mflo"}, out, exp_lo);
    ml = 1'b0; #1;
    check({tag, " out idle"}, out, 32'h0);
  endtask

  task automatic move_to(input logic hi_sel, input logic [31:0] val);
    HIw = hi_sel; LOw = !hi_sel; rs_data = val;
    tick();
    HIw = 1'b0; LOw = 1'b0;
    if (hi_sel) m_hi = val; else m_lo = val;
  endtask

  // inject: 0 none, 1 mtlo during busy cycle 2, 2 start(mult) during busy cycle 2
  task automatic run_op(input string tag, input logic [2:0] w, input logic [31:0] a,
                        input logic [31:0] b, input int n, input int inject,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start = 1'b1; way = w; rs_data = a; rt_data = b; md_d = 1'b1; #1;
    check({tag, " stall at start"}, 32'(md_stall), 32'h1);
    tick();
    start = 1'b0; way = 3'b000;
    for (int i = 1; i <= n; i++) begin
      ml = 1'b1;
      if (i == 2 && inject == 1) begin LOw = 1'b1; rs_data = 32'hDEAD_BEEF; end
      if (i == 2 && inject == 2) begin start = 1'b1; way = 3'b001; rs_data = 32'd5; rt_data = 32'd5; end
      #1;
      check($sformatf("%s busy c%0d", tag, i), 32'(busy), 32'h1);
      check($sformatf("%s stall c%0d", tag, i), 32'(md_stall), 32'h1);
      check($sformatf("%s old lo c%0d", tag, i), out, m_lo);
      tick();
      LOw = 1'b0; start = 1'b0; way = 3'b000;
    end
    ml = 1'b0; #1;
    check({tag, " busy done"}, 32'(busy), 32'h0);
    check({tag, " stall done"}, 32'(md_stall), 32'h0);
    md_d = 1'b0;
    m_hi = exp_hi;
    m_lo = exp_lo;
    chk_hilo(tag, m_hi, m_lo);
  endtask

  initial begin
    idle_inputs();
    m_hi = '0;
    m_lo = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    md_d = 1'b1; #1;
    check("reset busy", 32'(busy), 32'h0);
    check("reset stall", 32'(md_stall), 32'h0);
    md_d = 1'b0;
    chk_hilo("reset", 32'h0, 32'h0);

    run_op("mult -2*3", 3'b001, 32'hFFFF_FFFE, 32'd3, 5, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    move_to(1'b0, 32'h0BAD_F00D);
    chk_hilo("mtlo", 32'hFFFF_FFFF, 32'h0BAD_F00D);
    run_op("multu", 3'b010, 32'hFFFF_FFFE, 32'd3, 5, 0, 32'h0000_0002, 32'hFFFF_FFFA);

    run_op("div -7/2", 3'b011, 32'hFFFF_FFF9, 32'd2, 10, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 7/2", 3'b100, 32'd7, 32'd2, 10, 2, 32'h0000_0001, 32'h0000_0003);
    run_op("div ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 10, 0, 32'h0, 32'h8000_0000);
    run_op("multu max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5, 0, 32'h4000_0000, 32'h0);

    move_to(1'b1, 32'h0000_0011);
    move_to(1'b0, 32'h0000_0022);
    chk_hilo("mt pre div0", 32'h11, 32'h22);
    run_op("div by 0", 3'b011, 32'd5, 32'd0, 10, 0, 32'h11, 32'h22);
    run_op("divu by 0", 3'b100, 32'd9, 32'd0, 10, 0, 32'h11, 32'h22);

    move_to(1'b1, 32'hABCD_0000);
    chk_hilo("mthi", 32'hABCD_0000, 32'h22);

    // mthi with start=1 and an invalid way must be ignored
    start = 1'b1; way = 3'b111; HIw = 1'b1; rs_data = 32'h5555_5555;
    tick();
    start = 1'b0; way = 3'b000; HIw = 1'b0; #1;
    check("bad way busy", 32'(busy), 32'h0);
    chk_hilo("mthi with start", 32'hABCD_0000, 32'h22);

    // Reset during busy cycle 3 of a div aborts with no commit
    start = 1'b1; way = 3'b011; rs_data = 32'd100; rt_data = 32'd7; md_d = 1'b1;
    tick();
    start = 1'b0; way = 3'b000;
    tick();
    tick();
    #1;
    check("pre-abort busy", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    check("abort busy", 32'(busy), 32'h0);
    check("abort stall", 32'(md_stall), 32'h0);
    md_d = 1'b0;
    m_hi = '0;
    m_lo = '0;
    chk_hilo("abort", 32'h0, 32'h0);
    tick();
    check("abort stays idle", 32'(busy), 32'h0);
    chk_hilo("abort no commit", 32'h0, 32'h0);

    run_op("mult after rst", 3'b001, 32'd7, 32'hFFFF_FFFD, 5, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multiply/divide unit (MDU) for the P6 five-stage MIPS pipeline.
- Sits in the E stage, directly downstream of the instruction decoder; consumes the decoder's start, way, HIw, LOw, mh, ml and md outputs.
- Owns the HI/LO registers, models multi-cycle mult/div latency, and produces the busy/stall signal used by the hazard unit.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  E-stage instruction is mult/multu/div/divu.
- way  input  3  001 mult, 010 multu, 011 div, 100 divu; other values are ignored.
- HIw  input  1  E-stage mthi.
- LOw  input  1  E-stage mtlo.
- rs_data  input  32  forwarded rs operand; also the mthi/mtlo data.
- rt_data  input  32  forwarded rt operand.
- mh  input  1  E-stage mfhi.
- ml  input  1  E-stage mflo.
- md_d  input  1  D-stage instruction uses the MDU (decoder md).
- out  output  32  mfhi/mflo result to the E-stage result mux.
- busy  output  1  MDU computing.
- md_stall  output  1  stall request for D stage.

Behaviour:
- Reset: single clk; reset=1 at an edge clears the following.
  - HI=0, LO=0, counter=0, state=IDLE, pending result=0.
  - busy=0, md_stall=0, out=0.
  - Reset mid-operation aborts the operation; no commit occurs.
- States: IDLE and BUSY.
- IDLE, start=1 at edge T with a valid way:
  - Compute the 64-bit result from rs_data/rt_data and latch it into pending {hi,lo}.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to BUSY.
- BUSY:
  - busy=1 for exactly N cycles after edge T.
  - Counter decrements each edge.
  - At the edge ending the Nth busy cycle, HI/LO take pending values, state=IDLE, busy=0.
- Arithmetic:
  - mult: signed 32x32->64, HI=upper, LO=lower.
  - multu: unsigned.
  - div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - div 0x80000000/-1: LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divisor 0 (div/divu): full DIV_CYCLES busy period still runs; HI/LO unchanged at commit.
- mthi/mtlo:
  - In IDLE with start=0, HIw/LOw write rs_data to HI/LO at the next edge.
  - HIw and LOw are never both set.
  - In BUSY, or when start=1 in the same cycle, HIw/LOw are ignored. The hazard unit prevents this case; the bench checks it.
- Reads:
  - out = mh ? HI : ml ? LO : 0, combinational from the committed registers.
  - During BUSY, out returns the pre-operation HI/LO.
- start while BUSY: ignored; the state machine is not restarted.
- md_stall: combinational, = md_d & (start | busy).
  - Clears in the cycle state returns to IDLE, so the D-stage instruction issues the cycle after commit.
- Back-to-back: start may be accepted in the first IDLE cycle after commit.

Decomposition:
- Shared package `mdu_pkg`:
  - way codes WAY_MULT=3'b001, WAY_MULTU=3'b010, WAY_DIV=3'b011, WAY_DIVU=3'b100.
  - State enum {IDLE, BUSY}.
  - Default cycle constants.
- One optional sub-module, `mdu_arith`: purely combinational 64-bit result from way/operands, including div-by-zero and overflow rules. The FSM/counter and HI/LO registers stay in `mult_div_unit`.

Test Plan:
- mult, rs=0xFFFFFFFE, rt=3 -> busy=1 for cycles 1..5 (md_d=1 gives md_stall=1 over the same span); then HI=0xFFFFFFFF, LO=0xFFFFFFFA, and mfhi reads HI.
- multu, same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles; mflo during busy returns the old LO.
- div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 cycles; divu 7/2 -> LO=3, HI=1; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- div by zero with HI=0x11, LO=0x22 -> busy 10 cycles, then HI=0x11, LO=0x22 unchanged.
- mthi rs=0xABCD0000 in IDLE -> HI=0xABCD0000 next cycle; mtlo pulsed during BUSY -> LO unchanged; start pulsed during BUSY -> busy length unchanged.
- reset=1 at busy cycle 3 of a div -> next cycle busy=0, HI=LO=0, out=0, md_stall=0; a new mult started afterwards completes normally.
